// File: rtl/clock_div_prog.sv
// clock_div_prog: programmable integer clock divider.
//
// A free-running counter (0 .. N-1) divides CLK_IN by N = DIV_ACTIVE.
// CLK_OUT is high for the first ceil(N/2) counts of each period, and TICK_OUT
// strobes on the edge that starts a period (the "wrap" edge).
//
// New divisors are staged: a DIV_LOAD with DIV_IN >= 2 fills a pending slot
// (last load wins), and the slot is applied only on a wrap edge, so a period
// already in progress is never shortened. DIV_IN of 0 or 1 is refused with a
// one-cycle DIV_ERR pulse and leaves the pending slot untouched.
//
// Load handshake: DIV_LOAD is a single-cycle request with no ready. The
// divider accepts or refuses it on the same edge, independent of ENABLE.
// DIV_ERR (refused) shows the cycle after the request. DIV_ACK shows the cycle
// after the edge where the staged divisor actually takes effect.
//
// Optional build macro: CLOCK_DIV_PROG_SYNC_EN. When defined, SYNC_IN on an
// enabled edge forces an immediate wrap (phase restart). When undefined,
// SYNC_IN is ignored and no sync logic exists; the port list is the same.

module clock_div_prog #(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 26
) (
    input  logic             CLK_IN,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [CNT_W-1:0] DIV_IN,
    input  logic             DIV_LOAD,
    input  logic             SYNC_IN,
    output logic             CLK_OUT,
    output logic             TICK_OUT,
    output logic             DIV_ACK,
    output logic             DIV_ERR,
    output logic [CNT_W-1:0] DIV_ACTIVE
);

    localparam logic [CNT_W-1:0] DIV_DEF = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(DIV_DEFAULT - 1);

    // A default divisor below 2 or not representable in CNT_W bits is a build error.
    if ((DIV_DEFAULT < 2) || (64'(DIV_DEFAULT) >= (64'd1 << CNT_W))) begin : g_bad_default
        $error("clock_div_prog: DIV_DEFAULT must be >= 2 and < 2**CNT_W");
    end

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] pend_div;
    logic             pend_vld;

    logic             sync_hit;

`ifdef CLOCK_DIV_PROG_SYNC_EN
    assign sync_hit = SYNC_IN;
`else
    // SYNC_IN is kept on the port list but has no effect in this build.
    logic unused_sync;
    assign unused_sync = SYNC_IN;
    assign sync_hit    = 1'b0;
`endif

    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] div_next;
    logic [CNT_W:0]   high_len;
    logic             wrap;
    logic             apply;
    logic             load_ok;
    logic             clk_next;

    // Next count, wrap detection and the divisor in effect after this edge.
    always_comb begin
        count_next = count;
        if (ENABLE) begin
            if (sync_hit) begin
                count_next = '0;
            end else if (count == DIV_ACTIVE - 1'b1) begin
                count_next = '0;
            end else begin
                count_next = count + 1'b1;
            end
        end
        wrap     = ENABLE && (count_next == '0);
        // Only a divisor staged before this edge may take effect on it.
        apply    = wrap && pend_vld;
        div_next = apply ? pend_div : DIV_ACTIVE;
        // High phase length is ceil(N/2); one extra bit avoids overflow at N = 2**CNT_W-1.
        high_len = ({1'b0, div_next} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
        clk_next = ({1'b0, count_next} < high_len);
        load_ok  = DIV_LOAD && (DIV_IN > CNT_W'(1));
    end

    // Counter, divisor staging and registered outputs.
    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            count      <= CNT_RST;
            DIV_ACTIVE <= DIV_DEF;
            pend_div   <= '0;
            pend_vld   <= 1'b0;
            CLK_OUT    <= 1'b0;
            TICK_OUT   <= 1'b0;
            DIV_ACK    <= 1'b0;
            DIV_ERR    <= 1'b0;
        end else begin
            count      <= count_next;
            DIV_ACTIVE <= div_next;
            TICK_OUT   <= wrap;
            DIV_ACK    <= apply;
            DIV_ERR    <= DIV_LOAD && !load_ok;
            if (ENABLE) begin
                CLK_OUT <= clk_next;
            end
            // A load on the applying edge refills the slot for the next wrap.
            if (load_ok) begin
                pend_div <= DIV_IN;
                pend_vld <= 1'b1;
            end else if (apply) begin
                pend_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_div_prog.sv
// tb_clock_div_prog: self-checking bench for clock_div_prog (default parameters).
// Build macro CLOCK_DIV_PROG_SYNC_EN, if defined, also changes the expected
// behaviour of SYNC_IN here.

module tb_clock_div_prog;

    localparam int W     = 16;
    localparam int DIV_D = 26;
`ifdef CLOCK_DIV_PROG_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    logic         CLK_IN;
    logic         RESET;
    logic         ENABLE;
    logic [W-1:0] DIV_IN;
    logic         DIV_LOAD;
    logic         SYNC_IN;
    logic         CLK_OUT;
    logic         TICK_OUT;
    logic         DIV_ACK;
    logic         DIV_ERR;
    logic [W-1:0] DIV_ACTIVE;

    clock_div_prog #(.CNT_W(W), .DIV_DEFAULT(DIV_D)) dut (
        .CLK_IN     (CLK_IN),
        .RESET      (RESET),
        .ENABLE     (ENABLE),
        .DIV_IN     (DIV_IN),
        .DIV_LOAD   (DIV_LOAD),
        .SYNC_IN    (SYNC_IN),
        .CLK_OUT    (CLK_OUT),
        .TICK_OUT   (TICK_OUT),
        .DIV_ACK    (DIV_ACK),
        .DIV_ERR    (DIV_ERR),
        .DIV_ACTIVE (DIV_ACTIVE)
    );

    // ---------------- clock ----------------
    initial begin
        CLK_IN = 1'b0;
        forever #5 CLK_IN = ~CLK_IN;
    end

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks position inside the current period, the active divisor and a
    // queue of staged divisors (the newest entry is the one that counts).
    int m_elapsed;
    int m_n;
    int pend_q[$];
    bit m_clk, m_tick, m_ack, m_err;

    task automatic model_edge(input bit rst, input bit ena, input bit load,
                              input int din, input bit sync);
        bit had_pend;
        int pv;
        bit new_period;
        if (rst) begin
            m_n       = DIV_D;
            m_elapsed = DIV_D - 1;
            pend_q.delete();
            m_clk = 0; m_tick = 0; m_ack = 0; m_err = 0;
        end else begin
            had_pend = (pend_q.size() > 0);
            pv       = had_pend ? pend_q[$] : 0;
            m_err    = load && (din < 2);
            m_ack    = 0;
            m_tick   = 0;
            if (ena) begin
                new_period = (SYNC_EN && sync) || (m_elapsed + 1 >= m_n);
                if (new_period) begin
                    m_elapsed = 0;
                    if (had_pend) begin
                        m_n   = pv;
                        m_ack = 1;
                        pend_q.delete();
                    end
                end else begin
                    m_elapsed++;
                end
                m_tick = new_period;
                m_clk  = (2 * m_elapsed < m_n);
            end
            if (load && din >= 2) pend_q.push_back(din);
        end
    endtask

    task automatic check_model(input string pfx);
        chk({pfx, "_clk"},    CLK_OUT,    m_clk);
        chk({pfx, "_tick"},   TICK_OUT,   m_tick);
        chk({pfx, "_ack"},    DIV_ACK,    m_ack);
        chk({pfx, "_err"},    DIV_ERR,    m_err);
        chk({pfx, "_active"}, DIV_ACTIVE, m_n);
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after the active edge; outputs are sampled there too.
    task automatic drive_edge(input bit rst, input bit ena, input bit load,
                              input logic [W-1:0] din, input bit sync);
        RESET    = rst;
        ENABLE   = ena;
        DIV_LOAD = load;
        DIV_IN   = din;
        SYNC_IN  = sync;
        @(posedge CLK_IN);
        model_edge(rst, ena, load, int'(din), sync);
        #1;
    endtask

    task automatic idle(input bit ena);
        drive_edge(0, ena, 0, '0, 0);
    endtask

    task automatic do_reset();
        drive_edge(1, 0, 0, '0, 0);
        drive_edge(1, 1, 1, 16'd9, 1);   // reset must win over every other input
    endtask

    // Enabled edges until TICK_OUT, bounded; n counts edges including the tick edge.
    task automatic run_to_tick(input int max, output int n);
        n = 0;
        do begin
            idle(1);
            n++;
        end while (!TICK_OUT && n < max);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit           ena;
        bit           load;
        logic [W-1:0] din;
        bit           clk;
        bit           tick;
        bit           ack;
        bit           err;
        logic [W-1:0] act;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(bit ena, bit load, int din, bit clk, bit tick,
                                bit ack, bit err, int act);
        vec_t v;
        v.ena = ena; v.load = load; v.din = W'(din);
        v.clk = clk; v.tick = tick; v.ack = ack; v.err = err; v.act = W'(act);
        return v;
    endfunction

    initial begin
        int n;
        RESET = 1; ENABLE = 0; DIV_IN = '0; DIV_LOAD = 0; SYNC_IN = 0;

        // ---- reset state ----
        do_reset();
        chk("rst_clk",    CLK_OUT,    0);
        chk("rst_tick",   TICK_OUT,   0);
        chk("rst_ack",    DIV_ACK,    0);
        chk("rst_err",    DIV_ERR,    0);
        chk("rst_active", DIV_ACTIVE, DIV_D);

        // ---- table: loads, rejects, last-wins, ENABLE-independent loads ----
        vecs[0]  = mk(0, 1, 3, 0, 0, 0, 0, 26);  // staged while disabled
        vecs[1]  = mk(1, 0, 0, 1, 1, 1, 0, 3);   // first enabled edge wraps, applies 3
        vecs[2]  = mk(1, 0, 0, 1, 0, 0, 0, 3);
        vecs[3]  = mk(1, 0, 0, 0, 0, 0, 0, 3);
        vecs[4]  = mk(1, 0, 0, 1, 1, 0, 0, 3);
        vecs[5]  = mk(1, 1, 1, 1, 0, 0, 1, 3);   // reject 1
        vecs[6]  = mk(0, 0, 0, 1, 0, 0, 0, 3);   // hold
        vecs[7]  = mk(1, 1, 4, 0, 0, 0, 0, 3);
        vecs[8]  = mk(1, 0, 0, 1, 1, 1, 0, 4);   // apply 4 at wrap
        vecs[9]  = mk(1, 0, 0, 1, 0, 0, 0, 4);
        vecs[10] = mk(1, 0, 0, 0, 0, 0, 0, 4);
        vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 4);
        vecs[12] = mk(1, 0, 0, 1, 1, 0, 0, 4);
        vecs[13] = mk(0, 1, 0, 1, 0, 0, 1, 4);   // reject 0 while disabled
        vecs[14] = mk(1, 1, 2, 1, 0, 0, 0, 4);
        vecs[15] = mk(1, 1, 5, 0, 0, 0, 0, 4);   // overwrites 2
        vecs[16] = mk(1, 0, 0, 0, 0, 0, 0, 4);
        vecs[17] = mk(1, 0, 0, 1, 1, 1, 0, 5);   // last load wins
        for (int i = 0; i < 18; i++) begin
            drive_edge(0, vecs[i].ena, vecs[i].load, vecs[i].din, 0);
            chk($sformatf("vec%0d_clk", i),    CLK_OUT,    vecs[i].clk);
            chk($sformatf("vec%0d_tick", i),   TICK_OUT,   vecs[i].tick);
            chk($sformatf("vec%0d_ack", i),    DIV_ACK,    vecs[i].ack);
            chk($sformatf("vec%0d_err", i),    DIV_ERR,    vecs[i].err);
            chk($sformatf("vec%0d_active", i), DIV_ACTIVE, vecs[i].act);
        end

        // ---- default divider waveform, 100 cycles ----
        do_reset();
        for (int i = 1; i <= 100; i++) begin
            idle(1);
            chk($sformatf("def%0d_clk", i),  CLK_OUT,  (((i - 1) % 26) < 13));
            chk($sformatf("def%0d_tick", i), TICK_OUT, (((i - 1) % 26) == 0));
        end

        // ---- load 5 mid-period: period 26 completes, then 3 high / 2 low ----
        do_reset();
        idle(1);                             // tick, count 0
        for (int i = 0; i < 10; i++) idle(1); // count 10
        drive_edge(0, 1, 1, 16'd5, 0);
        chk("mid_noack", DIV_ACK, 0);
        run_to_tick(40, n);
        chk("mid_period", 11 + n, 26);
        chk("mid_ack",    DIV_ACK, 1);
        chk("mid_active", DIV_ACTIVE, 5);
        for (int k = 1; k <= 10; k++) begin
            idle(1);
            chk($sformatf("n5_%0d_clk", k),  CLK_OUT,  ((k % 5) < 3));
            chk($sformatf("n5_%0d_tick", k), TICK_OUT, ((k % 5) == 0));
        end

        // ---- reject on default divisor ----
        do_reset();
        idle(1);
        drive_edge(0, 1, 1, 16'd1, 0);
        chk("rej_err",    DIV_ERR, 1);
        idle(1);
        chk("rej_err_once", DIV_ERR, 0);
        run_to_tick(40, n);
        chk("rej_period", 2 + n, 26);
        chk("rej_active", DIV_ACTIVE, 26);

        // ---- ENABLE low for 10 cycles in high phase stretches period to 36 ----
        do_reset();
        for (int i = 0; i < 5; i++) idle(1);
        for (int i = 0; i < 10; i++) begin
            idle(0);
            chk($sformatf("hold%0d_clk", i),  CLK_OUT,  1);
            chk($sformatf("hold%0d_tick", i), TICK_OUT, 0);
        end
        run_to_tick(60, n);
        chk("hold_period", 14 + n, 36);

        // ---- reset discards pending divisor ----
        do_reset();
        drive_edge(0, 0, 1, 16'd5, 0);
        idle(1);
        chk("rp_active5", DIV_ACTIVE, 5);
        drive_edge(0, 1, 1, 16'd12, 0);
        drive_edge(1, 1, 0, '0, 0);
        chk("rp_clk",    CLK_OUT,    0);
        chk("rp_tick",   TICK_OUT,   0);
        chk("rp_active", DIV_ACTIVE, 26);
        idle(1);
        chk("rp_first_tick", TICK_OUT, 1);
        chk("rp_first_clk",  CLK_OUT,  1);
        chk("rp_first_ack",  DIV_ACK,  0);
        run_to_tick(40, n);
        chk("rp_period",     n, 26);
        chk("rp_no_apply",   DIV_ACK, 0);
        chk("rp_active_end", DIV_ACTIVE, 26);

        // ---- SYNC_IN at count 7 ----
        do_reset();
        for (int i = 0; i < 8; i++) idle(1); // count 7
        drive_edge(0, 1, 0, '0, 1);
        chk("sync_tick", TICK_OUT, SYNC_EN);
        chk("sync_clk",  CLK_OUT,  1);
        run_to_tick(40, n);
        chk("sync_period", n, SYNC_EN ? 26 : 18);
        drive_edge(0, 0, 0, '0, 1);         // ignored while disabled
        chk("sync_dis_tick", TICK_OUT, 0);

        // ---- randomized run against the reference model ----
        do_reset();
        check_model("rnd_rst");
        for (int i = 0; i < 3000; i++) begin
            bit r, e, l, s;
            logic [W-1:0] d;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) < 8);
            l = ($urandom_range(0, 19) == 0);
            s = ($urandom_range(0, 39) == 0);
            d = W'($urandom_range(0, 12));
            drive_edge(r, e, l, d, s);
            check_model($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
